// File: rtl/i2c_arbitro_transacciones.sv
// Round-robin arbiter placing two CPU requesters onto one I2C transaction generator.
// It latches the winning requester's operands, strobes the generator and returns the result.
module i2c_arbitro_transacciones #(
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int CNT_W          = 10
) (
    input  logic        clk_arbitro,
    input  logic        rst_arbitro,
    input  logic [1:0]  REQ,
    input  logic [1:0]  RNW_REQ,
    input  logic [6:0]  ADDR_REQ0,
    input  logic [6:0]  ADDR_REQ1,
    input  logic [15:0] WR_DATA_REQ0,
    input  logic [15:0] WR_DATA_REQ1,
    output logic [1:0]  GNT,
    output logic [1:0]  DONE,
    output logic [1:0]  ERR,
    output logic [15:0] RD_DATA,
    output logic        START_STB,
    output logic [6:0]  I2C_ADDR,
    output logic        RNW,
    output logic [15:0] WR_DATA,
    input  logic        GEN_BUSY,
    input  logic        GEN_DONE,
    input  logic        GEN_NACK,
    input  logic [15:0] GEN_RD_DATA
);

    typedef enum logic [1:0] {IDLE, START, ESPERA, RESPUESTA} state_t;

    // The counter holds k-1 during the k-th ESPERA cycle, so the last permitted cycle is TIMEOUT_CYCLES-1.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state_q, state_d;
    logic [1:0]        gnt_q, gnt_d;
    logic              last_q, last_d;
    logic [6:0]        addr_q, addr_d;
    logic              rnw_q, rnw_d;
    logic [15:0]       wdata_q, wdata_d;
    logic [15:0]       rd_q, rd_d;
    logic              status_q, status_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              win;

    always_ff @(posedge clk_arbitro or posedge rst_arbitro) begin
        if (rst_arbitro) begin
            state_q  <= IDLE;
            gnt_q    <= 2'b00;
            last_q   <= 1'b1;
            addr_q   <= 7'h00;
            rnw_q    <= 1'b0;
            wdata_q  <= 16'h0000;
            rd_q     <= 16'h0000;
            status_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            last_q   <= last_d;
            addr_q   <= addr_d;
            rnw_q    <= rnw_d;
            wdata_q  <= wdata_d;
            rd_q     <= rd_d;
            status_q <= status_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        last_d   = last_q;
        addr_d   = addr_q;
        rnw_d    = rnw_q;
        wdata_d  = wdata_q;
        rd_d     = rd_q;
        status_d = status_q;
        cnt_d    = cnt_q;
        // Under contention the requester not granted last wins; otherwise the lone requester wins.
        win      = (REQ == 2'b11) ? ~last_q : REQ[1];

        case (state_q)
            IDLE: begin
                if (REQ != 2'b00 && !GEN_BUSY) begin
                    gnt_d   = win ? 2'b10 : 2'b01;
                    last_d  = win;
                    addr_d  = win ? ADDR_REQ1 : ADDR_REQ0;
                    rnw_d   = RNW_REQ[win];
                    wdata_d = win ? WR_DATA_REQ1 : WR_DATA_REQ0;
                    state_d = START;
                end
            end
            START: begin
                cnt_d   = '0;
                state_d = ESPERA;
            end
            ESPERA: begin
                cnt_d = cnt_q + 1'b1;
                if (GEN_DONE) begin
                    rd_d     = GEN_RD_DATA;
                    status_d = GEN_NACK;
                    state_d  = RESPUESTA;
                end else if (cnt_q == CNT_LAST) begin
                    rd_d     = 16'h0000;
                    status_d = 1'b1;
                    state_d  = RESPUESTA;
                end
            end
            RESPUESTA: begin
                gnt_d   = 2'b00;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign GNT       = gnt_q;
    assign START_STB = (state_q == START);
    assign DONE      = (state_q == RESPUESTA) ? gnt_q : 2'b00;
    assign ERR       = (state_q == RESPUESTA && status_q) ? gnt_q : 2'b00;
    assign RD_DATA   = rd_q;
    assign I2C_ADDR  = addr_q;
    assign RNW       = rnw_q;
    assign WR_DATA   = wdata_q;

endmodule

// File: tb/tb_i2c_arbitro_transacciones.sv
// Self-checking bench: directed scenarios plus randomized transactions against a round-robin reference model.
// A second instance with an 8-cycle timeout covers the timeout path.
module tb_i2c_arbitro_transacciones;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  REQ = 2'b00;
    logic [1:0]  RNW_REQ = 2'b00;
    logic [6:0]  ADDR_REQ0 = 7'h00;
    logic [6:0]  ADDR_REQ1 = 7'h00;
    logic [15:0] WR_DATA_REQ0 = 16'h0000;
    logic [15:0] WR_DATA_REQ1 = 16'h0000;
    logic        GEN_BUSY = 1'b0;
    logic        GEN_DONE = 1'b0;
    logic        GEN_NACK = 1'b0;
    logic [15:0] GEN_RD_DATA = 16'h0000;

    logic [1:0]  gnt, done, err, toGnt, toDone, toErr;
    logic [15:0] rdData, wrData, toRdData, toWrData;
    logic [6:0]  i2cAddr, toI2cAddr;
    logic        startStb, rnw, toStartStb, toRnw;

    int passCount = 0;
    int checkCount = 0;
    int lastGrant = 1;

    always #5 clk = ~clk;

    i2c_arbitro_transacciones dut (
        .clk_arbitro(clk), .rst_arbitro(rst), .REQ(REQ), .RNW_REQ(RNW_REQ),
        .ADDR_REQ0(ADDR_REQ0), .ADDR_REQ1(ADDR_REQ1),
        .WR_DATA_REQ0(WR_DATA_REQ0), .WR_DATA_REQ1(WR_DATA_REQ1),
        .GNT(gnt), .DONE(done), .ERR(err), .RD_DATA(rdData), .START_STB(startStb),
        .I2C_ADDR(i2cAddr), .RNW(rnw), .WR_DATA(wrData),
        .GEN_BUSY(GEN_BUSY), .GEN_DONE(GEN_DONE), .GEN_NACK(GEN_NACK), .GEN_RD_DATA(GEN_RD_DATA)
    );

    i2c_arbitro_transacciones #(.TIMEOUT_CYCLES(8), .CNT_W(4)) dutTo (
        .clk_arbitro(clk), .rst_arbitro(rst), .REQ(REQ), .RNW_REQ(RNW_REQ),
        .ADDR_REQ0(ADDR_REQ0), .ADDR_REQ1(ADDR_REQ1),
        .WR_DATA_REQ0(WR_DATA_REQ0), .WR_DATA_REQ1(WR_DATA_REQ1),
        .GNT(toGnt), .DONE(toDone), .ERR(toErr), .RD_DATA(toRdData), .START_STB(toStartStb),
        .I2C_ADDR(toI2cAddr), .RNW(toRnw), .WR_DATA(toWrData),
        .GEN_BUSY(GEN_BUSY), .GEN_DONE(GEN_DONE), .GEN_NACK(GEN_NACK), .GEN_RD_DATA(GEN_RD_DATA)
    );

    task automatic applyReset;
        rst = 1'b1;
        REQ = 2'b00;
        GEN_BUSY = 1'b0;
        GEN_DONE = 1'b0;
        GEN_NACK = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        lastGrant = 1;
    endtask

    // One full transaction; entered and left at #1 after an edge with the DUT in IDLE.
    task automatic doTxn(input string tag, input logic [1:0] reqV, input logic [1:0] rnwV,
                         input logic [6:0] a0, input logic [6:0] a1,
                         input logic [15:0] w0, input logic [15:0] w1,
                         input int delay, input logic nack, input logic [15:0] rdV, input bit perturb);
        int expWin;
        int stb;
        logic [1:0] expOne, expErr;
        logic [23:0] expOps;
        REQ = reqV;
        RNW_REQ = rnwV;
        ADDR_REQ0 = a0;
        ADDR_REQ1 = a1;
        WR_DATA_REQ0 = w0;
        WR_DATA_REQ1 = w1;
        if (reqV == 2'b11) expWin = 1 - lastGrant;
        else expWin = (reqV == 2'b10) ? 1 : 0;
        lastGrant = expWin;
        expOne = (expWin == 1) ? 2'b10 : 2'b01;
        expErr = nack ? expOne : 2'b00;
        expOps = (expWin == 1) ? {a1, rnwV[1], w1} : {a0, rnwV[0], w0};

        @(posedge clk); #1;
        checkCount++;
        if ({gnt, startStb} !== {expOne, 1'b1}) $display("[TB] FAIL %s start: gnt/stb=%b/%b required %b/1", tag, gnt, startStb, expOne);
        else passCount++;
        checkCount++;
        if ({i2cAddr, rnw, wrData} !== expOps) $display("[TB] FAIL %s operands: got %h required %h", tag, {i2cAddr, rnw, wrData}, expOps);
        else passCount++;

        stb = 0;
        @(posedge clk); #1;
        for (int k = 1; k <= delay; k++) begin
            stb += int'(startStb);
            if (k == delay) begin
                GEN_DONE = 1'b1;
                GEN_NACK = nack;
                GEN_RD_DATA = rdV;
            end
            if (perturb) begin
                REQ = 2'($urandom);
                RNW_REQ = 2'($urandom);
                ADDR_REQ0 = 7'($urandom);
                ADDR_REQ1 = 7'($urandom);
                WR_DATA_REQ0 = 16'($urandom);
                WR_DATA_REQ1 = 16'($urandom);
            end
            @(posedge clk); #1;
        end
        GEN_DONE = 1'b0;
        GEN_NACK = 1'b0;
        GEN_RD_DATA = 16'($urandom);

        checkCount++;
        if ({done, err} !== {expOne, expErr}) $display("[TB] FAIL %s done/err: got %b/%b required %b/%b", tag, done, err, expOne, expErr);
        else passCount++;
        checkCount++;
        if (rdData !== rdV) $display("[TB] FAIL %s rd_data: got %h required %h", tag, rdData, rdV);
        else passCount++;
        checkCount++;
        if ({gnt, i2cAddr, rnw, wrData} !== {expOne, expOps} || stb != 0)
            $display("[TB] FAIL %s held: gnt=%b ops=%h stb=%0d required %b %h 0", tag, gnt, {i2cAddr, rnw, wrData}, stb, expOne, expOps);
        else passCount++;

        @(posedge clk); #1;
        checkCount++;
        if ({gnt, done, err, startStb} !== 7'b0) $display("[TB] FAIL %s idle: gnt/done/err/stb=%b%b%b%b required 0", tag, gnt, done, err, startStb);
        else passCount++;
    endtask

    task automatic test_reset;
        applyReset;
        checkCount++;
        if ({gnt, done, err, startStb, rnw, i2cAddr, wrData, rdData} !== 48'b0)
            $display("[TB] FAIL reset_state: got %h required 0", {gnt, done, err, startStb, rnw, i2cAddr, wrData, rdData});
        else passCount++;
        GEN_DONE = 1'b1;
        GEN_RD_DATA = 16'hFFFF;
        @(posedge clk); #1;
        GEN_DONE = 1'b0;
        @(posedge clk); #1;
        checkCount++;
        if ({done, err, gnt, rdData} !== 22'b0) $display("[TB] FAIL gen_done_in_idle: got %h required 0", {done, err, gnt, rdData});
        else passCount++;
    endtask

    task automatic test_single_write;
        doTxn("write0", 2'b01, 2'b00, 7'h3D, 7'h11, 16'hA5C3, 16'h1111, 20, 1'b0, 16'h0000, 1'b0);
        REQ = 2'b00;
    endtask

    task automatic test_back_to_back;
        applyReset;
        for (int t = 0; t < 3; t++)
            doTxn("rr", 2'b11, 2'b10, 7'h20 + 7'(t), 7'h40 + 7'(t), 16'h1000 + 16'(t), 16'h2000 + 16'(t), 3 + t, 1'b0, 16'hC000 + 16'(t), 1'b0);
        REQ = 2'b00;
    endtask

    task automatic test_read_and_nack;
        doTxn("read1", 2'b10, 2'b10, 7'h00, 7'h50, 16'h0000, 16'h0000, 5, 1'b0, 16'h1234, 1'b0);
        doTxn("nack0", 2'b01, 2'b00, 7'h10, 7'h50, 16'h5555, 16'h0000, 4, 1'b1, 16'h0000, 1'b0);
        REQ = 2'b00;
    endtask

    task automatic test_timeout;
        bit bad;
        applyReset;
        REQ = 2'b01;
        RNW_REQ = 2'b01;
        ADDR_REQ0 = 7'h22;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bad = 0;
        for (int k = 1; k < 8; k++) begin
            if (toDone !== 2'b00) bad = 1;
            @(posedge clk); #1;
        end
        if (toDone !== 2'b00) bad = 1;
        GEN_DONE = 1'b1;
        GEN_NACK = 1'b0;
        GEN_RD_DATA = 16'hBEEF;
        @(posedge clk); #1;
        GEN_DONE = 1'b0;
        checkCount++;
        if (bad || {toDone, toErr, toRdData} !== {2'b01, 2'b00, 16'hBEEF})
            $display("[TB] FAIL done_on_last_cycle: done/err/rd=%b/%b/%h early=%0d required 01/00/beef 0", toDone, toErr, toRdData, bad);
        else passCount++;

        @(posedge clk); #1;
        @(posedge clk); #1;
        checkCount++;
        if ({toGnt, toStartStb} !== 3'b011) $display("[TB] FAIL timeout_start: gnt/stb=%b/%b required 01/1", toGnt, toStartStb);
        else passCount++;
        @(posedge clk); #1;
        bad = 0;
        for (int k = 1; k < 8; k++) begin
            if (toDone !== 2'b00) bad = 1;
            @(posedge clk); #1;
        end
        if (toDone !== 2'b00) bad = 1;
        @(posedge clk); #1;
        checkCount++;
        if (bad || {toDone, toErr, toRdData} !== {2'b01, 2'b01, 16'h0000})
            $display("[TB] FAIL timeout: done/err/rd=%b/%b/%h early=%0d required 01/01/0000 0", toDone, toErr, toRdData, bad);
        else passCount++;
        applyReset;
    endtask

    task automatic test_busy_and_async_reset;
        bit bad;
        GEN_BUSY = 1'b1;
        REQ = 2'b01;
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            if (gnt !== 2'b00 || startStb !== 1'b0) bad = 1;
        end
        checkCount++;
        if (bad) $display("[TB] FAIL busy_hold: gnt/stb=%b/%b required 00/0", gnt, startStb);
        else passCount++;
        GEN_BUSY = 1'b0;
        doTxn("after_busy", 2'b01, 2'b01, 7'h33, 7'h44, 16'h0F0F, 16'hF0F0, 2, 1'b0, 16'h7777, 1'b0);

        ADDR_REQ0 = 7'h55;
        WR_DATA_REQ0 = 16'h9999;
        RNW_REQ = 2'b01;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 rst = 1'b1;
        #1;
        checkCount++;
        if ({gnt, done, err, startStb, rnw, i2cAddr, wrData, rdData} !== 48'b0)
            $display("[TB] FAIL async_reset: got %h required 0", {gnt, done, err, startStb, rnw, i2cAddr, wrData, rdData});
        else passCount++;
        @(posedge clk); #1;
        rst = 1'b0;
        lastGrant = 1;
        doTxn("post_reset", 2'b11, 2'b00, 7'h01, 7'h02, 16'hAAAA, 16'hBBBB, 3, 1'b0, 16'h4321, 1'b0);
        REQ = 2'b00;
    endtask

    task automatic test_random;
        for (int t = 0; t < 12; t++)
            doTxn("rand", 2'($urandom_range(1, 3)), 2'($urandom), 7'($urandom), 7'($urandom),
                  16'($urandom), 16'($urandom), $urandom_range(1, 30), 1'($urandom),
                  16'($urandom), bit'($urandom_range(0, 1)));
        REQ = 2'b00;
    endtask

    initial begin
        test_reset;
        test_single_write;
        test_back_to_back;
        test_read_and_nack;
        test_timeout;
        test_busy_and_async_reset;
        test_random;
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/i2c_arbitro_transacciones.md
Name: i2c_arbitro_transacciones

Overview:
- Arbitrates two CPU-side requesters sharing one I2C transaction generator.
- Latches the winning requester's address, RNW and write data, then issues a single start strobe to the generator.
- Waits for the generator to complete or for a timeout, then returns read data and status to the granted requester.
- Sits between the CPU register interface and the generator, which drives SCL/SDA toward receptor_transacciones.

Parameters:
TIMEOUT_CYCLES, 1023, number of ESPERA cycles without GEN_DONE before the transaction is aborted with an error.
CNT_W, 10, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
clk_arbitro  in  1  single clock for the whole block.
rst_arbitro  in  1  reset, asynchronous, active-high.
REQ  in  2  REQ[i]=1 means requester i wants a transaction; held until DONE[i].
RNW_REQ  in  2  RNW_REQ[i] is the read(1)/write(0) select for requester i.
ADDR_REQ0  in  7  I2C target address, requester 0.
ADDR_REQ1  in  7  I2C target address, requester 1.
WR_DATA_REQ0  in  16  write payload, requester 0.
WR_DATA_REQ1  in  16  write payload, requester 1.
GNT  out  2  one-hot grant, high from START through RESPUESTA.
DONE  out  2  one-cycle completion pulse to the granted requester.
ERR  out  2  valid with DONE; 1 means NACK or timeout.
RD_DATA  out  16  read data returned on DONE.
START_STB  out  1  one-cycle start pulse to the generator.
I2C_ADDR  out  7  latched address driven to the generator.
RNW  out  1  latched read/write select.
WR_DATA  out  16  latched write payload.
GEN_BUSY  in  1  generator is busy with a transaction.
GEN_DONE  in  1  one-cycle pulse: generator transaction finished.
GEN_NACK  in  1  valid with GEN_DONE; receiver did not ACK.
GEN_RD_DATA  in  16  valid with GEN_DONE.

Behaviour:
- Reset (asynchronous, any time, including mid-transaction): state IDLE; GNT, DONE, ERR, START_STB, RNW = 0; I2C_ADDR, WR_DATA, RD_DATA, timeout counter = 0; last-grant pointer = 1, so requester 0 wins the first contention.
- States: IDLE, START, ESPERA, RESPUESTA.
- IDLE:
  - If REQ != 0 and GEN_BUSY = 0, choose the winner. A single request wins outright. If both request, the winner is the requester not granted last (round-robin).
  - The winner's operands are latched into I2C_ADDR/RNW/WR_DATA, GNT is set, the pointer updates, and the next state is START.
  - If GEN_BUSY = 1, stay in IDLE with no grant.
- START: exactly one cycle. START_STB = 1 and the counter is cleared; next state is ESPERA.
- Latency: REQ sampled at edge N gives GNT and latched operands from N+1; START_STB is high during cycle N+1.
- ESPERA:
  - The counter increments each cycle.
  - GEN_DONE = 1: capture GEN_RD_DATA into RD_DATA and GEN_NACK into a status bit; go to RESPUESTA.
  - Counter reaches TIMEOUT_CYCLES with no GEN_DONE: status = 1 and RD_DATA = 16'h0000; go to RESPUESTA.
  - GEN_DONE in the same cycle the timeout is reached: GEN_DONE wins (data and NACK captured normally).
- RESPUESTA: exactly one cycle. DONE[g] = 1 and ERR[g] = status for the granted index g; the other bit of each stays 0. Next state IDLE, with GNT cleared on entry to IDLE.
- Back-to-back: at least one IDLE cycle separates transactions; a REQ still high in RESPUESTA is arbitrated in the following IDLE cycle.
- GEN_DONE outside ESPERA is ignored. START_STB is never reasserted before RESPUESTA.
- Latched operands are stable from START through RESPUESTA; changes on the REQ-side inputs during this window are ignored.
- REQ[g] dropped mid-transaction: the transaction still completes and DONE[g] is still pulsed.
- RD_DATA holds its last value between transactions. A write transaction updates RD_DATA with GEN_RD_DATA as given (don't-care to requesters).
- GNT is always one-hot or zero; DONE and ERR are never asserted together on both bits.

Test Plan:
1. Reset, then REQ=2'b01, ADDR_REQ0=7'h3D, RNW_REQ[0]=0, WR_DATA_REQ0=16'hA5C3; GEN_DONE after 20 cycles with NACK=0 -> one START_STB with I2C_ADDR=7'h3D, WR_DATA=16'hA5C3, RNW=0; DONE=2'b01, ERR=2'b00 one cycle after GEN_DONE.
2. REQ=2'b11 held through three transactions -> grants in order 01, 10, 01; each DONE pulse is on the matching bit.
3. Read by requester 1 (RNW_REQ[1]=1), GEN_RD_DATA=16'h1234 with GEN_DONE -> RD_DATA=16'h1234 and DONE=2'b10 in the same cycle.
4. GEN_DONE with GEN_NACK=1 (wrong address 7'h10) -> ERR=2'b01 with DONE=2'b01, then IDLE.
5. TIMEOUT_CYCLES=8 and GEN_DONE never asserted -> DONE and ERR on the granted bit 8 cycles after entering ESPERA, RD_DATA=16'h0000; a GEN_DONE landing on the 8th cycle gives ERR=0 instead.
6. GEN_BUSY=1 with REQ=2'b01 -> no GNT and no START_STB until GEN_BUSY falls. Assert rst_arbitro in ESPERA -> all outputs 0 immediately (asynchronously), next grant goes to requester 0.
